// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core memory-port arbiter: FSM states, requester IDs,
// the LSU operation bundle and the request presented on the shared port.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_IF, ARB_HOLD_LSU} arb_st_t;

  typedef enum logic {ARB_ID_IF, ARB_ID_LSU} arb_id_t;

  typedef enum logic [1:0] {NO_LSU, LSU_LOAD, LSU_STORE} lsu_op_typ_t;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} mem_size_t;

  typedef struct packed {
    lsu_op_typ_t op_typ;
    mem_size_t   width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } s_lsu_op_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    mem_size_t   size;
    logic [31:0] wdata;
  } s_mem_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs, one entry per accepted-but-unanswered
// transaction. Each pointer carries a wrap bit to tell full from empty.
module arb_id_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  arb_id_t id_i,
  input  logic    pop_i,
  output arb_id_t id_o,
  output logic    empty_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] wr_idx_q, rd_idx_q;
  logic          wr_wrap_q, rd_wrap_q;
  arb_id_t       mem_q [DEPTH];
  logic          full, do_push, do_pop;

  function automatic logic [IW:0] bump(input logic [IW-1:0] idx, input logic wrap);
    if (idx == IW'(DEPTH - 1)) return {~wrap, {IW{1'b0}}};
    return {wrap, idx + IW'(1)};
  endfunction

  assign empty_o = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
  assign full    = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
  assign id_o    = mem_q[rd_idx_q];
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_wrap_q <= 1'b0;
    end else begin
      if (do_push) {wr_wrap_q, wr_idx_q} <= bump(wr_idx_q, wr_wrap_q);
      if (do_pop)  {rd_wrap_q, rd_idx_q} <= bump(rd_idx_q, rd_wrap_q);
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read once the
  // pointers say it was written, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx_q] <= id_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared core memory port between instruction fetch and the LSU,
// tracks outstanding IDs in grant order and routes in-order responses back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  input  s_lsu_op_t   lsu_i,
  output logic        lsu_bp_o,
  output logic        lsu_rvalid_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_size_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  output logic        rsp_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_st_t    st_q;
  s_mem_req_t hold_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;

  logic       lsu_valid, slot_free, lsu_win, if_win;
  logic       req, hs, if_gnt, lsu_gnt, pop, fifo_empty;
  arb_id_t    head_id;
  s_mem_req_t if_req_s, lsu_req_s, cur_req;

  assign lsu_valid = lsu_i.op_typ != NO_LSU;
  assign slot_free = cnt_q != CW'(MAX_OUTSTANDING);

  assign if_req_s  = '{addr: if_addr_i, we: 1'b0, size: SIZE_WORD, wdata: '0};
  assign lsu_req_s = '{addr: lsu_i.addr, we: (lsu_i.op_typ == LSU_STORE),
                       size: lsu_i.width, wdata: lsu_i.wdata};

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    lsu_win = 1'b0;
    if_win  = 1'b0;
    cur_req = '0;
    case (st_q)
      ARB_IDLE: begin
        if (slot_free) begin
          if (lsu_valid && (starve_q < SW'(STARVE_LIMIT))) begin
            lsu_win = 1'b1;
            cur_req = lsu_req_s;
          end else if (if_req_i) begin
            if_win  = 1'b1;
            cur_req = if_req_s;
          end
        end
      end
      ARB_HOLD_IF: begin
        if_win  = 1'b1;
        cur_req = hold_q;
      end
      ARB_HOLD_LSU: begin
        lsu_win = 1'b1;
        cur_req = hold_q;
      end
      default: ;
    endcase
  end

  // Outputs are forced low while reset is held, even if requesters keep driving.
  assign req     = rst && (lsu_win || if_win);
  assign hs      = req && mem_ready_i;
  assign if_gnt  = hs && if_win;
  assign lsu_gnt = hs && lsu_win;
  assign pop     = rst && mem_rvalid_i && !fifo_empty;

  assign mem_req_o    = req;
  assign mem_addr_o   = req ? cur_req.addr : '0;
  assign mem_we_o     = req && cur_req.we;
  assign mem_size_o   = req ? cur_req.size : 2'b00;
  assign mem_wdata_o  = req ? cur_req.wdata : '0;
  assign if_gnt_o     = if_gnt;
  assign lsu_bp_o     = rst && lsu_valid && !lsu_gnt;
  assign if_rvalid_o  = pop && (head_id == ARB_ID_IF);
  assign lsu_rvalid_o = pop && (head_id == ARB_ID_LSU);
  assign rsp_err_o    = pop && mem_err_i;

  always_comb begin
    cnt_d    = cnt_q + CW'(hs) - CW'(pop);
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (lsu_gnt && if_req_i && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ARB_IDLE;
      hold_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      case (st_q)
        ARB_IDLE: begin
          if (req && !mem_ready_i) begin
            st_q   <= lsu_win ? ARB_HOLD_LSU : ARB_HOLD_IF;
            hold_q <= cur_req;
          end
        end
        default: begin
          if (mem_ready_i) st_q <= ARB_IDLE;
        end
      endcase
    end
  end

  arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (hs),
    .id_i    (lsu_win ? ARB_ID_LSU : ARB_ID_IF),
    .pop_i   (pop),
    .id_o    (head_id),
    .empty_o (fifo_empty)
  );

endmodule
